fifo_in_rd_statemachine: RTL
============================

FIFO_IN_RD_STATEMACHINE -- requirements
Module: fifo_in_rd_statemachine

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: start  input  1  one-cycle pulse; begins reading one trigger's data from FIFO_In.
REQ-004 SHALL have port: nPointsPerBin  input  16  samples per range bin; two samples per FIFO word, so words per bin = nPointsPerBin[15:1].
REQ-005 SHALL have port: nRangeBin  input  8  bins per trigger, noise bin included.
REQ-006 SHALL have port: fifo_empty  input  1  FIFO_In empty flag (FWFT FIFO: fifo_dout valid whenever fifo_empty=0).
REQ-007 SHALL have port: fifo_dout  input  32  FIFO_In head word.
REQ-008 SHALL have port: fifo_rd_en  output  1  pop FIFO_In head (combinational).
REQ-009 SHALL have port: m_data  output  32  registered word to downstream FFT/accumulator.
REQ-010 SHALL have port: m_valid  output  1  m_data valid.
REQ-011 SHALL have port: m_last  output  1  marks last word of a bin, qualified by m_valid.
REQ-012 SHALL have port: m_ready  input  1  downstream accepts when m_valid & m_ready.
REQ-013 SHALL have port: busy  output  1  high from accepted start until frame_done.
REQ-014 SHALL have port: frame_done  output  1  one-cycle pulse after last word of last bin is accepted.
REQ-015 SHALL have port: param_err  output  1  one-cycle pulse when start is rejected for zero parameters.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN; any unused encoding returns to IDLE.
REQ-017 IDLE: on start=1 with nPointsPerBin[15:1]!=0 and nRangeBin!=0, SHALL latch both parameters, clear counters, go to RUN next cycle.
REQ-018 IDLE: on start=1 with either value zero, SHALL stay IDLE and pulse param_err next cycle.
REQ-019 start in RUN or DRAIN SHALL be ignored; parameter input changes after latch SHALL not affect the frame.
REQ-020 Output register SHALL load when (m_valid=0 or m_ready=1); fifo_rd_en = RUN & !fifo_empty & load condition; on pop, m_data<=fifo_dout, m_valid<=1.
REQ-021 When load condition true and no pop, m_valid SHALL go 0; m_data/m_last SHALL hold while m_valid=1 and m_ready=0.
REQ-022 Full throughput: with fifo_empty=0 and m_ready=1, one word per cycle, latency fifo_rd_en -> m_valid = 1 cycle.
REQ-023 word counter (15 bit) SHALL increment per pop, wrap to 0 at latched words-per-bin-1; bin counter (8 bit) SHALL increment on that wrap.
REQ-024 m_last SHALL be registered with the word popped when word counter = words-per-bin-1.
REQ-025 Pop of last word of last bin SHALL move RUN -> DRAIN; no further pops in DRAIN.
REQ-026 DRAIN: when m_valid & m_ready (final word accepted), SHALL go IDLE and pulse frame_done that cycle +1; busy falls with frame_done.
REQ-027 fifo_empty=1 in RUN SHALL stall popping with counters held; no timeout.
REQ-028 m_ready=0 SHALL never cause loss or duplication of words.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, counters 0, m_data 0, m_valid 0, m_last 0, busy 0, frame_done 0, param_err 0, latched params 0.
REQ-030 Reset mid-frame SHALL abandon the frame without frame_done; FIFO contents untouched; first start after release begins a new frame.

Verification
REQ-031 nPointsPerBin=8, nRangeBin=3, FIFO preloaded 12 words, m_ready=1 -> 12 consecutive m_valid, m_last on words 4/8/12, frame_done 1 cycle after word 12, busy 13 cycles.
REQ-032 Same setup, m_ready toggled 1/0 each cycle -> identical 12-word sequence in order, no drops/duplicates, m_data stable while stalled.
REQ-033 fifo_empty asserted for 5 cycles after word 6 -> m_valid gap, counters hold, m_last still on words 4/8/12.
REQ-034 start with nPointsPerBin=1 (words=0) -> param_err pulse, busy stays 0, fifo_rd_en never 1.
REQ-035 rst=0 after word 5 of the REQ-031 frame -> all outputs 0 immediately, no frame_done; new start yields fresh frame starting with word counter 0.
REQ-036 second start pulse mid-frame plus nRangeBin changed to 1 -> ignored; frame completes with 3 bins.

Source files
------------

// File: rtl/fifo_in_rd_statemachine_if.sv
// FIFO_In read port and downstream word stream of the bin reader.
// master: the reader; slave: FIFO plus downstream consumer.
interface fifo_in_rd_statemachine_if;
   logic        fifo_empty;
   logic [31:0] fifo_dout;
   logic        fifo_rd_en;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd_en,
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd_en,
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/fifo_in_rd_statemachine.sv
// Reads one trigger's words from FIFO_In and streams them out bin by bin,
// marking the last word of each bin and pulsing frame_done at the end.
module fifo_in_rd_statemachine (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] nPointsPerBin,
   input  logic [7:0]  nRangeBin,
   fifo_in_rd_statemachine_if.master bus,
   output logic        busy,
   output logic        frame_done,
   output logic        param_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [14:0] wpb_q, wpb_d;
   logic [14:0] word_q, word_d;
   logic [7:0]  nbin_q, nbin_d;
   logic [7:0]  bin_q, bin_d;
   logic [31:0] m_data_q, m_data_d;
   logic        m_valid_q, m_valid_d;
   logic        m_last_q, m_last_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        param_err_q, param_err_d;

   logic        params_ok;
   logic        load;
   logic        pop;
   logic        word_wrap;
   logic        bin_end;
   logic        unused_lsb;

   // Two samples per word, so the sample-count LSB never matters.
   assign unused_lsb = nPointsPerBin[0];

   assign params_ok = (nPointsPerBin[15:1] != 15'd0) && (nRangeBin != 8'd0);
   assign load      = !m_valid_q || bus.m_ready;
   assign pop       = (state_q == RUN) && !bus.fifo_empty && load;
   assign word_wrap = (word_q == wpb_q - 15'd1);
   assign bin_end   = (bin_q == nbin_q - 8'd1);

   always_comb begin
      state_d      = state_q;
      wpb_d        = wpb_q;
      nbin_d       = nbin_q;
      word_d       = word_q;
      bin_d        = bin_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      param_err_d  = 1'b0;

      if (pop) begin
         m_data_d  = bus.fifo_dout;
         m_valid_d = 1'b1;
         m_last_d  = word_wrap;
      end else if (load) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (params_ok) begin
                  wpb_d   = nPointsPerBin[15:1];
                  nbin_d  = nRangeBin;
                  word_d  = 15'd0;
                  bin_d   = 8'd0;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end else begin
                  param_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (pop) begin
               if (word_wrap) begin
                  word_d = 15'd0;
                  bin_d  = bin_q + 8'd1;
                  if (bin_end) state_d = DRAIN;
               end else begin
                  word_d = word_q + 15'd1;
               end
            end
         end
         DRAIN: begin
            // Final word is still in the output register until accepted.
            if (m_valid_q && bus.m_ready) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
               frame_done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         wpb_q        <= 15'd0;
         nbin_q       <= 8'd0;
         word_q       <= 15'd0;
         bin_q        <= 8'd0;
         m_data_q     <= 32'd0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         param_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wpb_q        <= wpb_d;
         nbin_q       <= nbin_d;
         word_q       <= word_d;
         bin_q        <= bin_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         param_err_q  <= param_err_d;
      end
   end

   assign bus.fifo_rd_en = pop;
   assign bus.m_data     = m_data_q;
   assign bus.m_valid    = m_valid_q;
   assign bus.m_last     = m_last_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;
   assign param_err      = param_err_q;

endmodule
